multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and write-back.
- Drives every datapath select and write strobe: PC, IR, register file, ALU, immediate extender (ExtOp), data memory.
- Sits beside the datapath; decodes opcode/funct from IR and the ALU zero flag.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_ORI, 6'b001101, ori opcode
- OP_LUI, 6'b001111, lui opcode
- OP_LW, 6'b100011, lw opcode
- OP_SW, 6'b101011, sw opcode
- OP_BEQ, 6'b000100, beq opcode
- OP_J, 6'b000010, j opcode

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag
- PCWr  out  1  PC write enable
- NPCOp  out  2  00 PC+4, 01 branch target, 10 jump target
- IRWr  out  1  IR load enable
- RegWr  out  1  register file write enable
- RegDst  out  2  00 rt, 01 rd
- WDSel  out  2  00 ALU result, 01 memory data
- ALUSrc  out  1  0 register B, 1 extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 or
- ExtOp  out  2  00 zero-extend, 01 sign-extend, 10 lui shift
- MemWr  out  1  data memory write enable
- state  out  3  current state, debug only

Behaviour:
- Reset: rst high at a clock edge -> state=FETCH. While rst is high, PCWr, IRWr, RegWr and MemWr are forced 0. rst mid-instruction aborts it with no further strobes.
- States: FETCH=0, DECODE=1, EXE=2, MEMRD=3, MEMWR=4, WB=5, BR=6. Next state is registered; outputs are combinational from state and op (Moore per state, op-qualified).
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next: DECODE.
- DECODE:
  - j: PCWr=1, NPCOp=10 -> FETCH.
  - beq -> BR.
  - R-type with funct addu (100001) or subu (100011), ori, lui, lw, sw -> EXE.
  - Any other op/funct: no strobes -> FETCH (NOP).
- EXE, operand selects held constant for the whole state:
  - addu: ALUSrc=0, ALUOp=000.
  - subu: ALUSrc=0, ALUOp=001.
  - ori: ALUSrc=1, ExtOp=00, ALUOp=010.
  - lui: ALUSrc=1, ExtOp=10, ALUOp=000 (rs ignored; the ALU adds $0).
  - lw/sw: ALUSrc=1, ExtOp=01, ALUOp=000.
  - Next state: lw -> MEMRD; sw -> MEMWR; others -> WB.
- MEMWR: MemWr=1 for exactly one cycle; EXE selects held. Next: FETCH.
- MEMRD: no strobes; EXE selects held. Next: WB.
- WB: RegWr=1 for exactly one cycle.
  - R-type: RegDst=01, WDSel=00.
  - ori/lui: RegDst=00, WDSel=00.
  - lw: RegDst=00, WDSel=01.
  - Next: FETCH.
- BR: ALUSrc=0, ALUOp=001, ExtOp=01. If zero=1: PCWr=1, NPCOp=01. Next: FETCH.
- Defaults when not specified: all strobes 0, selects 0.
- Latency in cycles: j 2; beq 3; sw 4; R-type/ori/lui 4; lw 5; illegal 2.
- op and funct are sampled only in DECODE and later states; IR is stable after FETCH.
- Only one write strobe among RegWr and MemWr is ever high in a cycle. PCWr is never high outside FETCH, DECODE (j) and BR.

Test Plan:
- rst=1 for 3 cycles, then 0, op=OP_RTYPE, funct=100001 -> state sequence 0,1,2,5,0. RegWr=1 only in WB with RegDst=01, WDSel=00. Strobes 0 during reset.
- op=OP_LUI -> EXE drives ExtOp=10, ALUSrc=1. WB drives RegWr=1, RegDst=00. Total 4 cycles.
- op=OP_LW, then op=OP_SW -> lw visits 0,1,2,3,5 with ExtOp=01 and WDSel=01 in WB. sw visits 0,1,2,4 with MemWr=1 exactly one cycle.
- op=OP_BEQ with zero=1, then zero=0 -> in BR, PCWr=1 with NPCOp=01 in the first case, PCWr=0 in the second. Both return to FETCH after 3 cycles.
- op=OP_J, then op=6'b111111 -> j asserts PCWr=1, NPCOp=10 in DECODE. Illegal op produces no strobes. Both return to FETCH after 2 cycles.
- Assert rst in MEMWR of an sw -> MemWr=0 that cycle, state=FETCH on the next edge, no RegWr afterwards.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control: FETCH/DECODE/EXE/MEMRD/MEMWR/WB/BR sequencing, outputs combinational from state/op.
// Latency 2..5 cycles per instruction (j/illegal 2, beq 3, R/ori/lui/sw 4, lw 5); no backpressure, rst forces all write strobes low.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_ORI   = 6'b001101,
  parameter logic [5:0] OP_LUI   = 6'b001111,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       IRWr,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] ExtOp,
  output logic       MemWr,
  output logic [2:0] state
);

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEMRD  = 3'd3,
    MEMWR  = 3'd4,
    WB     = 3'd5,
    BR     = 3'd6
  } state_t;

  state_t cur_st, nxt_st;

  logic is_rtype_ok;
  logic exe_legal;
  logic       alusrc_e;
  logic [2:0] aluop_e;
  logic [1:0] extop_e;
  logic       pcwr_i, irwr_i, regwr_i, memwr_i;

  assign is_rtype_ok = (op == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU));
  assign exe_legal   = is_rtype_ok || (op == OP_ORI) || (op == OP_LUI) ||
                       (op == OP_LW) || (op == OP_SW);
  assign state = cur_st;

  always_ff @(posedge clk) begin
    if (rst) cur_st <= FETCH;
    else     cur_st <= nxt_st;
  end

  // Operand selects for the execute phase, reused while the memory cycle runs.
  always_comb begin
    alusrc_e = 1'b0;
    aluop_e  = 3'b000;
    extop_e  = 2'b00;
    case (op)
      OP_RTYPE: aluop_e = (funct == FN_SUBU) ? 3'b001 : 3'b000;
      OP_ORI: begin
        alusrc_e = 1'b1;
        aluop_e  = 3'b010;
      end
      OP_LUI: begin
        alusrc_e = 1'b1;
        extop_e  = 2'b10;
      end
      OP_LW, OP_SW: begin
        alusrc_e = 1'b1;
        extop_e  = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_st  = cur_st;
    pcwr_i  = 1'b0;
    irwr_i  = 1'b0;
    regwr_i = 1'b0;
    memwr_i = 1'b0;
    NPCOp   = 2'b00;
    RegDst  = 2'b00;
    WDSel   = 2'b00;
    ALUSrc  = 1'b0;
    ALUOp   = 3'b000;
    ExtOp   = 2'b00;
    case (cur_st)
      FETCH: begin
        irwr_i = 1'b1;
        pcwr_i = 1'b1;
        nxt_st = DECODE;
      end
      DECODE: begin
        if (op == OP_J) begin
          pcwr_i = 1'b1;
          NPCOp  = 2'b10;
          nxt_st = FETCH;
        end else if (op == OP_BEQ) begin
          nxt_st = BR;
        end else if (exe_legal) begin
          nxt_st = EXE;
        end else begin
          nxt_st = FETCH;
        end
      end
      EXE: begin
        ALUSrc = alusrc_e;
        ALUOp  = aluop_e;
        ExtOp  = extop_e;
        if (op == OP_LW)      nxt_st = MEMRD;
        else if (op == OP_SW) nxt_st = MEMWR;
        else                  nxt_st = WB;
      end
      MEMRD: begin
        ALUSrc = alusrc_e;
        ALUOp  = aluop_e;
        ExtOp  = extop_e;
        nxt_st = WB;
      end
      MEMWR: begin
        ALUSrc  = alusrc_e;
        ALUOp   = aluop_e;
        ExtOp   = extop_e;
        memwr_i = 1'b1;
        nxt_st  = FETCH;
      end
      WB: begin
        regwr_i = 1'b1;
        RegDst  = (op == OP_RTYPE) ? 2'b01 : 2'b00;
        WDSel   = (op == OP_LW) ? 2'b01 : 2'b00;
        nxt_st  = FETCH;
      end
      BR: begin
        ALUOp = 3'b001;
        ExtOp = 2'b01;
        if (zero) begin
          pcwr_i = 1'b1;
          NPCOp  = 2'b01;
        end
        nxt_st = FETCH;
      end
      default: nxt_st = FETCH;
    endcase
  end

  // Reset squashes every architectural write in the same cycle.
  assign PCWr  = pcwr_i  & ~rst;
  assign IRWr  = irwr_i  & ~rst;
  assign RegWr = regwr_i & ~rst;
  assign MemWr = memwr_i & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random instruction stream against a per-cycle instruction-level model, plus literal spot checks.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef struct packed {
    logic [2:0] state;
    logic       pcwr;
    logic [1:0] npcop;
    logic       irwr;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       alusrc;
    logic [2:0] aluop;
    logic [1:0] extop;
    logic       memwr;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       PCWr, IRWr, RegWr, ALUSrc, MemWr;
  logic [1:0] NPCOp, RegDst, WDSel, ExtOp;
  logic [2:0] ALUOp, state;

  outs_t dut_o, exp_o;
  outs_t snap [8];
  logic  exp_vld = 1'b0;
  int    errors = 0;
  int    checks = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RegWr(RegWr),
    .RegDst(RegDst), .WDSel(WDSel), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .ExtOp(ExtOp), .MemWr(MemWr), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_o = {state, PCWr, NPCOp, IRWr, RegWr, RegDst, WDSel,
                  ALUSrc, ALUOp, ExtOp, MemWr};

  function automatic bit legal_exe(input logic [5:0] o, input logic [5:0] f);
    return (o == OP_RTYPE && (f == FN_ADDU || f == FN_SUBU)) ||
           o == OP_ORI || o == OP_LUI || o == OP_LW || o == OP_SW;
  endfunction

  function automatic int lat(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_J)      return 2;
    if (o == OP_BEQ)    return 3;
    if (o == OP_LW)     return 5;
    if (o == OP_SW)     return 4;
    if (legal_exe(o, f)) return 4;
    return 2;
  endfunction

  // Expected outputs at cycle k of an instruction (k=0 is the fetch cycle).
  function automatic outs_t model(input int k, input logic [5:0] o,
                                  input logic [5:0] f, input logic z);
    outs_t r;
    r = '0;
    if (k == 0) begin
      r.irwr = 1'b1;
      r.pcwr = 1'b1;
      return r;
    end
    if (k == 1) begin
      r.state = 3'd1;
      if (o == OP_J) begin
        r.pcwr  = 1'b1;
        r.npcop = 2'b10;
      end
      return r;
    end
    if (o == OP_BEQ) begin
      r.state = 3'd6;
      r.aluop = 3'b001;
      r.extop = 2'b01;
      r.pcwr  = z;
      r.npcop = z ? 2'b01 : 2'b00;
      return r;
    end
    if (k == 2 || (k == 3 && (o == OP_LW || o == OP_SW))) begin
      r.alusrc = (o != OP_RTYPE);
      r.aluop  = (o == OP_RTYPE && f == FN_SUBU) ? 3'b001 :
                 (o == OP_ORI) ? 3'b010 : 3'b000;
      r.extop  = (o == OP_LUI) ? 2'b10 :
                 (o == OP_LW || o == OP_SW) ? 2'b01 : 2'b00;
      r.state  = (k == 2) ? 3'd2 : (o == OP_LW) ? 3'd3 : 3'd4;
      r.memwr  = (k == 3 && o == OP_SW);
      return r;
    end
    r.state  = 3'd5;
    r.regwr  = 1'b1;
    r.regdst = (o == OP_RTYPE) ? 2'b01 : 2'b00;
    r.wdsel  = (o == OP_LW) ? 2'b01 : 2'b00;
    return r;
  endfunction

  function automatic outs_t strip(input outs_t i);
    outs_t r;
    r = i;
    r.pcwr  = 1'b0;
    r.irwr  = 1'b0;
    r.regwr = 1'b0;
    r.memwr = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_vld) begin
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL cycle_compare t=%0t op=%b funct=%b rst=%b got=%h exp=%h",
                 $time, op, funct, rst, dut_o, exp_o);
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  // zmode: 0/1 fixed zero flag, 2 random each cycle; abort_at: cycle index to pulse rst, -1 for none.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input int zmode, input int abort_at);
    int n;
    n = lat(iop, ifn);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst   = (k == abort_at);
      op    = (k == 0) ? 6'($urandom) : iop;
      funct = (k == 0) ? 6'($urandom) : ifn;
      zero  = (zmode == 2) ? 1'($urandom) : zmode[0];
      exp_o = rst ? strip(model(k, iop, ifn, zero)) : model(k, iop, ifn, zero);
      exp_vld = 1'b1;
      #2 snap[k] = dut_o;
      if (rst) break;
    end
  endtask

  initial begin
    logic [5:0] pool [8];
    logic [5:0] rop, rfn;
    int ab;
    pool[0] = OP_RTYPE; pool[1] = OP_ORI; pool[2] = OP_LUI; pool[3] = OP_LW;
    pool[4] = OP_SW;    pool[5] = OP_BEQ; pool[6] = OP_J;   pool[7] = 6'b111111;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      op      = 6'($urandom);
      exp_o   = '0;
      exp_vld = 1'b1;
    end

    run_instr(OP_RTYPE, FN_ADDU, 0, -1);
    check_lit("addu_state_exe", int'(snap[2].state), 2);
    check_lit("addu_state_wb", int'(snap[3].state), 5);
    check_lit("addu_wb_regdst", int'(snap[3].regdst), 1);
    check_lit("addu_wb_regwr", int'(snap[3].regwr), 1);

    run_instr(OP_LUI, 6'd0, 0, -1);
    check_lit("lui_exe_extop", int'(snap[2].extop), 2);
    check_lit("lui_exe_alusrc", int'(snap[2].alusrc), 1);
    check_lit("lui_wb_regdst", int'(snap[3].regdst), 0);

    run_instr(OP_LW, 6'd0, 0, -1);
    check_lit("lw_memrd_state", int'(snap[3].state), 3);
    check_lit("lw_exe_extop", int'(snap[2].extop), 1);
    check_lit("lw_wb_wdsel", int'(snap[4].wdsel), 1);

    run_instr(OP_SW, 6'd0, 0, -1);
    check_lit("sw_memwr_state", int'(snap[3].state), 4);
    check_lit("sw_memwr_strobe", int'(snap[3].memwr), 1);

    run_instr(OP_BEQ, 6'd0, 1, -1);
    check_lit("beq_taken_pcwr", int'(snap[2].pcwr), 1);
    check_lit("beq_taken_npcop", int'(snap[2].npcop), 1);
    run_instr(OP_BEQ, 6'd0, 0, -1);
    check_lit("beq_nt_pcwr", int'(snap[2].pcwr), 0);

    run_instr(OP_J, 6'd0, 0, -1);
    check_lit("j_npcop", int'(snap[1].npcop), 2);
    check_lit("j_pcwr", int'(snap[1].pcwr), 1);
    run_instr(6'b111111, 6'd0, 0, -1);
    check_lit("illegal_strobes", int'({snap[1].pcwr, snap[1].irwr, snap[1].regwr, snap[1].memwr}), 0);

    run_instr(OP_SW, 6'd0, 0, 3);
    check_lit("abort_memwr", int'(snap[3].memwr), 0);
    run_instr(OP_ORI, 6'd0, 0, -1);
    check_lit("abort_refetch_state", int'(snap[0].state), 0);
    check_lit("ori_exe_aluop", int'(snap[2].aluop), 2);

    for (int i = 0; i < 400; i++) begin
      rop = pool[$urandom_range(7)];
      if ($urandom_range(3) == 0) rop = 6'($urandom);
      case ($urandom_range(2))
        0:       rfn = FN_ADDU;
        1:       rfn = FN_SUBU;
        default: rfn = 6'($urandom);
      endcase
      ab = ($urandom_range(24) == 0) ? int'($urandom_range(lat(rop, rfn) - 1)) : -1;
      run_instr(rop, rfn, 2, ab);
    end

    @(posedge clk);
    #1 exp_vld = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
